// File: rtl/target_locator.sv
// Reduces a binarized pixel stream to one bounding box, centre and hit count per frame.
// Results are registered one cycle after the vsync fall is seen and flagged by a one-cycle result_valid.
module target_locator #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int MIN_PIXELS = 200,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W*IMG_H+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic          per_img_Bit,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [XW-1:0] center_x,
  output logic [YW-1:0] center_y,
  output logic [CW-1:0] pix_cnt,
  output logic          target_found,
  output logic          result_valid
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    ACTIVE,
    LATCH
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW:0]   Y_END  = (YW+1)'(IMG_H);

  state_t        state, state_nxt;
  logic          vsync_r, href_r;
  logic          vs_rise, vs_fall, hs_fall;
  logic          pix_acc, hit;

  logic [XW-1:0] x;
  logic          x_ovf;
  logic [YW:0]   y;   // one extra bit so the row count can saturate at IMG_H
  logic [CW-1:0] cnt;
  logic [XW-1:0] acc_xmin, acc_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax;

  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          found_c;

  assign vs_rise = per_frame_vsync & ~vsync_r;
  assign vs_fall = ~per_frame_vsync & vsync_r;
  assign hs_fall = ~per_frame_href & href_r;

  assign pix_acc = per_frame_vsync & per_frame_href & per_frame_clken;
  // x never exceeds IMG_W-1, so columns past the line end are rejected by x_ovf alone
  assign hit     = pix_acc & per_img_Bit & ~x_ovf & (y < Y_END);

  assign sum_x   = {1'b0, acc_xmin} + {1'b0, acc_xmax};
  assign sum_y   = {1'b0, acc_ymin} + {1'b0, acc_ymax};
  assign found_c = (32'(cnt) >= 32'(MIN_PIXELS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOW:  if (!per_frame_vsync) state_nxt = WAIT_RISE;
      WAIT_RISE: if (vs_rise)          state_nxt = ACTIVE;
      ACTIVE:    if (vs_fall)          state_nxt = LATCH;
      LATCH:                           state_nxt = WAIT_RISE;
      default:                         state_nxt = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r  <= 1'b0;
      href_r   <= 1'b0;
      x        <= '0;
      x_ovf    <= 1'b0;
      y        <= '0;
      cnt      <= '0;
      acc_xmin <= '1;
      acc_xmax <= '0;
      acc_ymin <= '1;
      acc_ymax <= '0;
    end else begin
      vsync_r <= per_frame_vsync;
      href_r  <= per_frame_href;
      case (state)
        WAIT_RISE: begin
          if (vs_rise) begin
            x        <= '0;
            x_ovf    <= 1'b0;
            y        <= '0;
            cnt      <= '0;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
          end
        end
        ACTIVE: begin
          if (!vs_fall) begin
            if (pix_acc) begin
              if (x != X_LAST) x <= x + 1'b1;
              else             x_ovf <= 1'b1;
            end
            if (hit) begin
              if (cnt != '1) cnt <= cnt + 1'b1;
              if (x < acc_xmin)          acc_xmin <= x;
              if (x > acc_xmax)          acc_xmax <= x;
              if (y[YW-1:0] < acc_ymin)  acc_ymin <= y[YW-1:0];
              if (y[YW-1:0] > acc_ymax)  acc_ymax <= y[YW-1:0];
            end
            if (hs_fall) begin
              x     <= '0;
              x_ovf <= 1'b0;
              if (y != Y_END) y <= y + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      center_x     <= '0;
      center_y     <= '0;
      pix_cnt      <= '0;
      target_found <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state == LATCH) begin
        result_valid <= 1'b1;
        pix_cnt      <= cnt;
        target_found <= found_c;
        if (found_c) begin
          x_min    <= acc_xmin;
          x_max    <= acc_xmax;
          y_min    <= acc_ymin;
          y_max    <= acc_ymax;
          center_x <= sum_x[XW:1];
          center_y <= sum_y[YW:1];
        end else begin
          x_min    <= '0;
          x_max    <= '0;
          y_min    <= '0;
          y_max    <= '0;
          center_x <= '0;
          center_y <= '0;
        end
      end
    end
  end

endmodule
